score_cell_engine: RTL and testbench
====================================

SCORE_CELL_ENGINE -- requirements
Module: score_cell_engine

Interface
REQ-001 Parameter N, default 128, sequence length; matrix is (N+1)x(N+1), row/column 0 pre-initialised.
REQ-002 Parameter BitAddr, default $clog2(N+1), index width is BitAddr+1 bits.
REQ-003 Parameters MATCH (+1), MISMATCH (-1), GAP (-2), 9-bit two's-complement score constants.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a fill pass; ignored while busy=1.
REQ-008 char_a, char_b  in  2 each  nucleotide codes of seq A[i-1] and seq B[j-1], valid while i/j are stable.
REQ-009 signal  in  1  neighbour-read-complete flag from the score manager.
REQ-010 diag, left, up  in  9 each  neighbour scores (two's complement) from the score manager.
REQ-011 i, j  out  BitAddr+1 each  current cell coordinates.
REQ-012 en_read, en_counter_3  out  1 each  neighbour-read enables.
REQ-013 we, en_ins  out  1 each  score write strobes.
REQ-014 max  out  9  computed cell score.
REQ-015 dir  out  2  traceback direction; dir_we  out  1  direction write strobe.
REQ-016 busy  out  1  pass in progress; done  out  1  one-cycle end-of-pass pulse.

Function
REQ-017 FSM states: IDLE, READ, CALC, WRITE, NEXT, DONE.
REQ-018 IDLE: i=1, j=1, all strobes 0; start=1 -> READ.
REQ-019 READ: en_read=1, en_counter_3=1; stays until signal=1, then -> CALC.
REQ-020 CALC: captures diag/left/up and char_a/char_b; registers max and dir; all strobes 0; -> WRITE.
REQ-021 s_diag = diag + (char_a==char_b ? MATCH : MISMATCH); s_up = up + GAP; s_left = left + GAP.
REQ-022 Sums computed at 10 bits, saturated to 9-bit range [-256, +255].
REQ-023 max = largest of the three; ties resolved diag > up > left.
REQ-024 dir encoding: 2'b01 diag, 2'b10 up, 2'b11 left; 2'b00 only at reset/IDLE.
REQ-025 WRITE: we=1, en_ins=1, dir_we=1 for exactly one cycle, max/dir/i/j stable -> NEXT.
REQ-026 NEXT: row-major advance; j<N: j=j+1; j==N and i<N: j=1, i=i+1; i==N and j==N: -> DONE; else -> READ.
REQ-027 DONE: done=1 for one cycle, busy=0 -> IDLE; i/j return to 1.
REQ-028 busy=1 in all states except IDLE and DONE.
REQ-029 Per-cell latency: 4 cycles plus READ dwell; exactly N*N write strobes per pass.
REQ-030 start asserted in DONE or in any busy state has no effect.
REQ-031 signal outside READ is ignored.

Reset
REQ-032 rst=1 forces IDLE immediately, with any pass abandoned, no write strobe issued afterwards.
REQ-033 Reset values: i=1, j=1, max=0, dir=2'b00, all strobes/busy/done=0.

Structure
REQ-034 Shared package nw_pkg holds SCORE_W=9, dir codes, MATCH/MISMATCH/GAP defaults, saturate function.
REQ-035 One combinational sub-module max3_sel (three 9-bit scores in, max and dir out, REQ-023 priority).

Verification
REQ-036 N=2, diag=0, up=0, left=0, chars equal -> max=+1, dir=01, four WRITE pulses, then done.
REQ-037 Tie: diag=-1 mismatch (-2), up=0 (-2), left=5 (+3) -> max=3, dir=11; up=0, left=0, diag=-3 mismatch -> max=-2, dir=10.
REQ-038 Saturation: diag=255 match -> max=255; all inputs -256 -> max=-256.
REQ-039 N=3 coordinate order observed on WRITE: (1,1),(1,2),(1,3),(2,1)...(3,3), then done pulse, busy=0.
REQ-040 rst asserted during READ of cell (2,2) -> next cycle IDLE, i=j=1, no further we; a new start replays from (1,1).
REQ-041 start pulsed while busy, and signal pulsed in IDLE -> no state change, no extra writes.

Source files
------------

// File: rtl/nw_pkg.sv
// -----------------------------------------------------------------------------
// nw_pkg
// Shared definitions for the Needleman-Wunsch score-cell engine.
//   SCORE_W / SUM_W    : score width and the one-bit-wider accumulation width
//   score_t            : 9-bit two's-complement score
//   dir_t              : traceback direction codes (00 none, 01 diag, 10 up, 11 left)
//   state_t            : cell engine FSM states
//   MATCH/MISMATCH/GAP : default scoring constants
//   saturate / add_sat : clamp a widened sum back into the score range
// -----------------------------------------------------------------------------
package nw_pkg;

    localparam int SCORE_W = 9;
    localparam int SUM_W   = SCORE_W + 1;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic signed [SUM_W-1:0]   sum_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_DIAG = 2'b01,
        DIR_UP   = 2'b10,
        DIR_LEFT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CALC,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam score_t MATCH_DEF    = 9'sd1;
    localparam score_t MISMATCH_DEF = -9'sd1;
    localparam score_t GAP_DEF      = -9'sd2;

    localparam sum_t   SUM_HI   = 10'sd255;
    localparam sum_t   SUM_LO   = -10'sd256;
    localparam score_t SCORE_HI = 9'sh0FF;
    localparam score_t SCORE_LO = 9'sh100;

    // Clamp a 10-bit sum into [-256, +255].
    function automatic score_t saturate(input sum_t x);
        score_t r;
        if (x > SUM_HI) begin
            r = SCORE_HI;
        end else if (x < SUM_LO) begin
            r = SCORE_LO;
        end else begin
            r = x[SCORE_W-1:0];
        end
        return r;
    endfunction

    // Sign-extend both operands by one bit so the add cannot wrap, then clamp.
    function automatic score_t add_sat(input score_t a, input score_t b);
        sum_t s;
        s = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
        return saturate(s);
    endfunction

endpackage

// File: rtl/max3_sel.sv
// -----------------------------------------------------------------------------
// max3_sel
// Combinational three-way maximum with traceback direction.
// Ties resolve diag first, then up, then left.
//   s_diag, s_up, s_left : in  candidate scores (9-bit signed)
//   max                  : out winning score
//   dir                  : out direction code of the winner
// -----------------------------------------------------------------------------
module max3_sel
    import nw_pkg::*;
(
    input  logic signed [SCORE_W-1:0] s_diag,
    input  logic signed [SCORE_W-1:0] s_up,
    input  logic signed [SCORE_W-1:0] s_left,
    output logic signed [SCORE_W-1:0] max,
    output logic [1:0]                dir
);

    // NOTE: every output gets a default first so no path through the
    // block leaves a value unassigned, which would infer a latch.
    always_comb begin
        max = s_diag;
        dir = DIR_DIAG;
        if ((s_diag >= s_up) && (s_diag >= s_left)) begin
            max = s_diag;
            dir = DIR_DIAG;
        end else if (s_up >= s_left) begin
            max = s_up;
            dir = DIR_UP;
        end else begin
            max = s_left;
            dir = DIR_LEFT;
        end
    end

endmodule

// File: rtl/score_cell_engine.sv
// -----------------------------------------------------------------------------
// score_cell_engine
// Walks the interior cells (1..N, 1..N) of an (N+1)x(N+1) Needleman-Wunsch
// matrix in row-major order. For each cell it requests the three neighbour
// scores, computes the best score and traceback direction, and strobes the
// result out for one cycle.
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : pulse to begin a pass (ignored unless idle)
//   char_a, char_b        : nucleotide codes of A[i-1] and B[j-1]
//   signal                : neighbour scores are valid (honoured in READ only)
//   diag, left, up        : neighbour scores
//   i, j                  : current cell coordinates
//   en_read, en_counter_3 : neighbour-read enables (READ state)
//   we, en_ins, dir_we    : one-cycle write strobes (WRITE state)
//   max, dir              : registered cell score and traceback direction
//   busy, done            : pass in progress / one-cycle end-of-pass pulse
// -----------------------------------------------------------------------------
module score_cell_engine
    import nw_pkg::*;
#(
    parameter int                        N        = 128,
    parameter int                        BitAddr  = $clog2(N + 1),
    parameter logic signed [SCORE_W-1:0] MATCH    = MATCH_DEF,
    parameter logic signed [SCORE_W-1:0] MISMATCH = MISMATCH_DEF,
    parameter logic signed [SCORE_W-1:0] GAP      = GAP_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                char_a,
    input  logic [1:0]                char_b,
    input  logic                      signal,
    input  logic signed [SCORE_W-1:0] diag,
    input  logic signed [SCORE_W-1:0] left,
    input  logic signed [SCORE_W-1:0] up,
    output logic [BitAddr:0]          i,
    output logic [BitAddr:0]          j,
    output logic                      en_read,
    output logic                      en_counter_3,
    output logic                      we,
    output logic                      en_ins,
    output logic signed [SCORE_W-1:0] max,
    output logic [1:0]                dir,
    output logic                      dir_we,
    output logic                      busy,
    output logic                      done
);

    localparam int              IDX_W = BitAddr + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    state_t state;
    state_t state_nx;

    score_t s_diag;
    score_t s_up;
    score_t s_left;
    score_t sel_max;
    logic [1:0] sel_dir;

    // ---------------------------------------------------------------------
    // Candidate scores. Inputs are only consumed in CALC, where the score
    // manager holds them stable.
    // ---------------------------------------------------------------------
    always_comb begin
        s_diag = add_sat(diag, (char_a == char_b) ? MATCH : MISMATCH);
        s_up   = add_sat(up,   GAP);
        s_left = add_sat(left, GAP);
    end

    max3_sel u_max3_sel (
        .s_diag (s_diag),
        .s_up   (s_up),
        .s_left (s_left),
        .max    (sel_max),
        .dir    (sel_dir)
    );

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)  state_nx = ST_READ;
            ST_READ:  if (signal) state_nx = ST_CALC;
            ST_CALC:  state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_NEXT;
            ST_NEXT:  state_nx = ((i == LAST) && (j == LAST)) ? ST_DONE : ST_READ;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs decoded from the state
    // ---------------------------------------------------------------------
    always_comb begin
        en_read      = 1'b0;
        en_counter_3 = 1'b0;
        we           = 1'b0;
        en_ins       = 1'b0;
        dir_we       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            ST_READ: begin
                en_read      = 1'b1;
                en_counter_3 = 1'b1;
                busy         = 1'b1;
            end
            ST_CALC: busy = 1'b1;
            ST_WRITE: begin
                we     = 1'b1;
                en_ins = 1'b1;
                dir_we = 1'b1;
                busy   = 1'b1;
            end
            ST_NEXT: busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Coordinates and result registers. max/dir load at the end of CALC so
    // they are already stable throughout WRITE. The coordinate wrap back to
    // (1,1) happens on the last NEXT, so DONE and IDLE both show i=j=1.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i   <= ONE;
            j   <= ONE;
            max <= '0;
            dir <= DIR_NONE;
        end else begin
            case (state)
                ST_CALC: begin
                    max <= sel_max;
                    dir <= sel_dir;
                end
                ST_NEXT: begin
                    if (j != LAST) begin
                        j <= j + ONE;
                    end else if (i != LAST) begin
                        j <= ONE;
                        i <= i + ONE;
                    end else begin
                        i <= ONE;
                        j <= ONE;
                    end
                end
                ST_DONE, ST_IDLE: begin
                    i   <= ONE;
                    j   <= ONE;
                    dir <= DIR_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_cell_engine.sv
// -----------------------------------------------------------------------------
// tb_score_cell_engine
// Drives score_cell_engine (N=3) as the score manager would: waits for the
// neighbour-read request, answers after a random dwell, and checks every
// written cell against a reference computed from the scoring rules.
// -----------------------------------------------------------------------------
module tb_score_cell_engine;

    localparam int N  = 3;
    localparam int BA = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        char_a;
    logic [1:0]        char_b;
    logic              signal;
    logic signed [8:0] diag;
    logic signed [8:0] left;
    logic signed [8:0] up;
    logic [BA:0]       i;
    logic [BA:0]       j;
    logic              en_read;
    logic              en_counter_3;
    logic              we;
    logic              en_ins;
    logic signed [8:0] max;
    logic [1:0]        dir;
    logic              dir_we;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;
    int n_we  = 0;

    score_cell_engine #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .char_a       (char_a),
        .char_b       (char_b),
        .signal       (signal),
        .diag         (diag),
        .left         (left),
        .up           (up),
        .i            (i),
        .j            (j),
        .en_read      (en_read),
        .en_counter_3 (en_counter_3),
        .we           (we),
        .en_ins       (en_ins),
        .max          (max),
        .dir          (dir),
        .dir_we       (dir_we),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Counts write strobes seen at each rising edge.
    always @(posedge clk) begin
        if (we) n_we++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference scoring: plain integer arithmetic with clamping.
    function automatic int clamp(input int v);
        if (v > 255)  return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    function automatic void ref_cell(input int d, input int u, input int l, input bit eq,
                                     output int m, output int dr);
        int sd;
        int su;
        int sl;
        sd = clamp(d + (eq ? 1 : -1));
        su = clamp(u - 2);
        sl = clamp(l - 2);
        m  = sd;
        dr = 1;
        if (su > m) begin m = su; dr = 2; end
        if (sl > m) begin m = sl; dr = 3; end
    endfunction

    function automatic int rnd_score();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 255;
        if (r == 1) return -256;
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    // Directed cells used for the first pass.
    int t_d  [6] = '{0, -1, -3, 255, -256, 255};
    int t_u  [6] = '{0,  0,  0,   0, -256, 255};
    int t_l  [6] = '{0,  5,  0,   0, -256, 255};
    bit t_eq [6] = '{1,  0,  0,   1,    0,   1};

    task automatic wait_read(output bit ok);
        int t;
        t = 0;
        while (!en_read && t < 40) begin
            @(negedge clk);
            t++;
        end
        ok = en_read;
    endtask

    task automatic do_cell(input int d, input int u, input int l, input bit eq,
                           input int ei, input int ej, input bit chaos);
        int m;
        int dr;
        int ca;
        int cb;
        int t;
        bit ok;
        wait_read(ok);
        check("read_req", int'(en_read), 1);
        if (!ok) return;
        check("read_i", int'(i), ei);
        check("read_j", int'(j), ej);
        check("read_cnt3", int'(en_counter_3), 1);
        check("read_busy", int'(busy), 1);
        // Random read dwell, with stray start pulses while busy.
        repeat ($urandom_range(0, 3)) begin
            if (chaos) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("dwell_we", int'(we), 0);
        end
        ca     = int'($urandom_range(0, 3));
        cb     = eq ? ca : (ca + int'($urandom_range(1, 3))) % 4;
        char_a = 2'(ca);
        char_b = 2'(cb);
        diag   = 9'(d);
        up     = 9'(u);
        left   = 9'(l);
        signal = 1'b1;
        @(negedge clk);
        signal = 1'b0;
        check("calc_strobes", int'({en_read, we, en_ins, dir_we}), 0);
        t = 0;
        while (!we && t < 10) begin
            @(negedge clk);
            t++;
        end
        ref_cell(d, u, l, eq, m, dr);
        check("write_we", int'(we), 1);
        check("write_ins_dirwe", int'({en_ins, dir_we}), 3);
        check("write_i", int'(i), ei);
        check("write_j", int'(j), ej);
        check("write_max", int'(max), m);
        check("write_dir", int'(dir), dr);
        // Signal outside READ must be ignored.
        if (chaos) signal = 1'b1;
        @(negedge clk);
        signal = 1'b0;
        check("next_we", int'(we), 0);
        check("next_max_hold", int'(max), m);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input bit directed, input bit chaos, input int abort_at);
        int base;
        int t;
        int d;
        int u;
        int l;
        bit eq;
        bit ok;
        base = n_we;
        pulse_start();
        for (int k = 0; k < N * N; k++) begin
            if (k == abort_at) begin
                wait_read(ok);
                check("abort_read", int'(en_read), 1);
                check("abort_ij", int'({i, j}), (2 << (BA + 1)) | 2);
                rst = 1'b1;
                #1;
                check("abort_busy", int'(busy), 0);
                check("abort_read_off", int'(en_read), 0);
                check("abort_i", int'(i), 1);
                check("abort_j", int'(j), 1);
                base = n_we;
                @(negedge clk);
                rst = 1'b0;
                repeat (4) begin
                    signal = 1'b1;
                    @(negedge clk);
                    signal = 1'b0;
                    @(negedge clk);
                    check("idle_sig_busy", int'(busy), 0);
                end
                check("abort_no_we", n_we - base, 0);
                return;
            end
            if (directed && k < 6) begin
                d = t_d[k]; u = t_u[k]; l = t_l[k]; eq = t_eq[k];
            end else begin
                d = rnd_score(); u = rnd_score(); l = rnd_score(); eq = 1'($urandom_range(0, 1));
            end
            do_cell(d, u, l, eq, k / N + 1, k % N + 1, chaos);
        end
        t = 0;
        while (!done && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("done_ij", int'({i, j}), (1 << (BA + 1)) | 1);
        check("write_count", n_we - base, N * N);
        // start in DONE must not launch a new pass.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_dir", int'(dir), 0);
        @(negedge clk);
        check("idle_stays", int'({busy, en_read}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        signal = 1'b0;
        char_a = '0;
        char_b = '0;
        diag   = '0;
        up     = '0;
        left   = '0;
        repeat (2) @(negedge clk);
        check("rst_i", int'(i), 1);
        check("rst_j", int'(j), 1);
        check("rst_max", int'(max), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_strobes", int'({en_read, en_counter_3, we, en_ins, dir_we, busy, done}), 0);
        rst = 1'b0;
        @(negedge clk);
        // signal in IDLE is ignored
        signal = 1'b1;
        @(negedge clk);
        signal = 1'b0;
        @(negedge clk);
        check("idle_signal", int'({busy, en_read}), 0);

        run_pass(1'b1, 1'b0, -1);
        run_pass(1'b0, 1'b1, -1);
        run_pass(1'b0, 1'b0, 4);
        run_pass(1'b0, 1'b0, -1);
        repeat (3) run_pass(1'b0, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
